// File: rtl/mdu_ctrl.sv
// Iterative RV32M multiply/divide unit: shift-add MUL, restoring DIV, one bit per cycle.
// Latency XLEN+1 (1 for div-by-zero/overflow); stalls Execute while busy, abortable at any point.
module mdu_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            startE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] srcAE,
  input  logic [XLEN-1:0] srcBE,
  input  logic            abort,
  output logic            stall_mdu,
  output logic            done,
  output logic [XLEN-1:0] resultE,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic              aneg_q, aneg_d;
  logic              spec_q, spec_d;

  logic            sign_a, sign_b, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, accept, last;
  logic [XLEN:0]   div_shift;
  logic [XLEN-1:0] div_sub;
  logic            div_ge;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] res_quo, res_rem, res;

  // Operand decode in Execute; only used in the accepting cycle.
  always_comb begin
    sign_a   = (funct3E == 3'b001) | (funct3E == 3'b010) | (funct3E == 3'b100) | (funct3E == 3'b110);
    sign_b   = (funct3E == 3'b001) | (funct3E == 3'b100) | (funct3E == 3'b110);
    a_neg    = sign_a & srcAE[XLEN-1];
    b_neg    = sign_b & srcBE[XLEN-1];
    a_mag    = a_neg ? ('0 - srcAE) : srcAE;
    b_mag    = b_neg ? ('0 - srcBE) : srcBE;
    div_zero = funct3E[2] & (srcBE == '0);
    div_ovf  = funct3E[2] & ~funct3E[0] & (srcAE == {1'b1, {(XLEN-1){1'b0}}}) & (&srcBE);
    accept   = (state_q == S_IDLE) & startE & ~abort;
    last     = (cnt_q == CNT_W'(XLEN-1));
  end

  // acc_q holds {remainder, quotient/dividend} during DIV.
  always_comb begin
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_ge    = (div_shift >= {1'b0, opb_q});
    div_sub   = div_shift[XLEN-1:0] - opb_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    opb_d   = opb_q;
    f3_d    = f3_q;
    neg_d   = neg_q;
    aneg_d  = aneg_q;
    spec_d  = spec_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          f3_d    = funct3E;
          neg_d   = a_neg ^ b_neg;
          aneg_d  = a_neg;
          spec_d  = 1'b0;
          cnt_d   = '0;
          mcand_d = {{XLEN{1'b0}}, a_mag};
          opb_d   = b_mag;
          if (!funct3E[2]) begin
            acc_d   = '0;
            state_d = S_MUL;
          end else if (div_zero) begin
            acc_d   = {srcAE, {XLEN{1'b1}}};
            spec_d  = 1'b1;
            state_d = S_DONE;
          end else if (div_ovf) begin
            acc_d   = {{XLEN{1'b0}}, srcAE};
            spec_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            acc_d   = {{XLEN{1'b0}}, a_mag};
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        acc_d   = acc_q + (opb_q[0] ? mcand_q : '0);
        mcand_d = mcand_q << 1;
        opb_d   = opb_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (abort)     state_d = S_IDLE;
        else if (last) state_d = S_DONE;
      end
      S_DIV: begin
        acc_d = {(div_ge ? div_sub : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
        cnt_d = cnt_q + 1'b1;
        if (abort)     state_d = S_IDLE;
        else if (last) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sign correction; special-case divides already hold their final values.
  always_comb begin
    prod    = neg_q ? ('0 - acc_q) : acc_q;
    res_quo = acc_q[XLEN-1:0];
    res_rem = acc_q[2*XLEN-1:XLEN];
    if (!spec_q) begin
      if (neg_q)  res_quo = '0 - acc_q[XLEN-1:0];
      if (aneg_q) res_rem = '0 - acc_q[2*XLEN-1:XLEN];
    end
    if (f3_q[2])               res = f3_q[1] ? res_rem : res_quo;
    else if (f3_q[1:0] == 2'b00) res = prod[XLEN-1:0];
    else                       res = prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    stall_mdu = rst_n & (accept | (state_q == S_MUL) | (state_q == S_DIV));
    done      = (state_q == S_DONE) & ~abort;
    resultE   = done ? res : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      opb_q   <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      aneg_q  <= 1'b0;
      spec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      opb_q   <= opb_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
      aneg_q  <= aneg_d;
      spec_q  <= spec_d;
    end
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameters: XLEN, default 32, operand/result width; CNT_W, default 6, iteration counter width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 startE  in  1  Execute stage holds a valid RV32M instruction.
REQ-005 funct3E  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 srcAE, srcBE  in  XLEN each  forwarded operands (rs1, rs2) from Execute.
REQ-007 abort  in  1  kill in-flight operation (trap/flush from a later stage).
REQ-008 stall_mdu  out  1  hold Fetch, Decode, Execute; ORed with the load-use stall by the pipeline.
REQ-009 done  out  1  one-cycle pulse: result valid, Execute may advance.
REQ-010 resultE  out  XLEN  operation result, valid only while done=1.
REQ-011 busy  out  1  FSM not in IDLE.

Function
REQ-012 FSM states: IDLE, MUL, DIV, DONE.
REQ-013 IDLE & startE & !abort: latch operands and funct3E; go to MUL (funct3E[2]=0) or DIV (funct3E[2]=1); clear counter.
REQ-014 stall_mdu = (IDLE & startE & !abort) | MUL | DIV; combinational from startE in IDLE so the issuing cycle already stalls.
REQ-015 MUL: shift-add, one multiplicand bit per cycle on |operands| per signedness (MULH both signed, MULHSU rs1 signed only, MUL/MULHU unsigned); 64-bit accumulator.
REQ-016 DIV: restoring divide, one quotient bit per cycle on |operands| (DIV/REM signed, DIVU/REMU unsigned).
REQ-017 MUL/DIV leave to DONE when counter reaches XLEN-1; exactly XLEN cycles in MUL or DIV.
REQ-018 Latency: startE seen in IDLE at cycle T -> done=1 at T+XLEN+1; stall_mdu high T..T+XLEN (XLEN+1 cycles).
REQ-019 Sign fix in DONE: negate product if signs differ; quotient negated if signs differ; remainder takes dividend sign.
REQ-020 resultE: MUL low XLEN bits; MULH/MULHSU/MULHU high XLEN bits; DIV/DIVU quotient; REM/REMU remainder.
REQ-021 Divide by zero: skip DIV, go IDLE->DONE; quotient all ones, remainder = dividend; stall_mdu high one cycle.
REQ-022 Signed overflow (DIV/REM, rs1 = 0x80000000, rs2 = 0xFFFFFFFF): skip DIV; quotient 0x80000000, remainder 0.
REQ-023 DONE: done=1, stall_mdu=0, startE ignored (same instruction still in Execute); next state IDLE.
REQ-024 Back-to-back: startE in the cycle after DONE is a new instruction and is accepted per REQ-013.
REQ-025 abort in MUL/DIV/DONE: next state IDLE, no done pulse; stall_mdu drops the cycle after abort.
REQ-026 abort in IDLE: startE not accepted; stall_mdu=0.
REQ-027 Latched operands unaffected by srcAE/srcBE changes after acceptance.

Reset
REQ-028 rst_n=0 at any time, including mid-operation: immediately state IDLE, counter 0, accumulators 0, stall_mdu=0, done=0, busy=0, resultE=0.
REQ-029 First accepted start no earlier than the first rising edge with rst_n=1.

Verification
REQ-030 MUL 7 x 6 -> stall_mdu high 33 cycles, done pulse at T+33, resultE=0x0000002A.
REQ-031 MULH 0xFFFFFFFF x 0xFFFFFFFF -> resultE=0x00000000; MULHU same operands -> 0xFFFFFFFE.
REQ-032 DIV -7 / 2 -> quotient 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; 33-cycle stall each.
REQ-033 DIVU 5 / 0 -> 0xFFFFFFFF, REMU 5 % 0 -> 0x5, DIV 0x80000000 / -1 -> 0x80000000; each with done at T+1.
REQ-034 abort at cycle T+10 of a DIV -> no done, stall_mdu=0 from T+11, busy=0; following MUL 3 x 3 -> 9.
REQ-035 rst_n low at T+5 of a MUL -> all outputs 0 asynchronously; after release, DIVU 100 / 7 -> 0x0000000E.
